// File: rtl/cpu_rf_wb_arb_pkg.sv
// Shared definitions for the CPU register-file write-back path.
package cpu_pkg;
    localparam int NUM_REGS = 16;

    typedef logic [3:0] reg_sel_t;

    localparam int REQ_ALU = 0;
    localparam int REQ_LD  = 1;
    localparam int REQ_ACC = 2;
endpackage

// File: rtl/cpu_rf_wb_arb_rr_arbiter.sv
// Round-robin grant over NREQ requesters; the pointer advances only on an accepted grant.
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] grant
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] last_grant;
    logic [PW-1:0] next_idx;
    logic          found;
    int            idx;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        next_idx = last_grant;
        idx      = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_grant) + i) % NREQ;
            if (!found && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_idx   = PW'(idx);
            end
        end
    end

    // A grant is only ever given to a valid requester, so found means a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= PW'(NREQ - 1);
        else if (found)
            last_grant <= next_idx;
    end
endmodule

// File: rtl/cpu_rf_wb_arb.sv
// Write-back arbiter for the register-file write port with a pending-write scoreboard.
module cpu_rf_wb_arb
    import cpu_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0][3:0]     req_sel,
    input  logic [NREQ-1:0][DW-1:0]  req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rf_wrt_en,
    output reg_sel_t                 rf_wrt_sel,
    output logic [DW-1:0]            rf_wrt_data,
    input  logic                     iss_en,
    input  reg_sel_t                 iss_sel,
    input  reg_sel_t                 chk_sel1,
    input  reg_sel_t                 chk_sel2,
    output logic                     hazard,
    output logic [NUM_REGS-1:0]      pending,
    output logic                     r0_err,
    output logic                     iss_err
);
    logic                xfer;
    reg_sel_t            xfer_sel;
    logic [DW-1:0]       xfer_data;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic                iss_err_d;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (req_valid),
        .grant (req_ready)
    );

    always_comb begin
        xfer      = |req_ready;
        xfer_sel  = '0;
        xfer_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                xfer_sel  = req_sel[i];
                xfer_data = req_data[i];
            end
        end
    end

    // R0 writes are swallowed here; only a non-zero payload is flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wrt_en   <= 1'b0;
            rf_wrt_sel  <= '0;
            rf_wrt_data <= '0;
            r0_err      <= 1'b0;
        end else begin
            rf_wrt_en <= xfer && (xfer_sel != 4'd0);
            r0_err    <= xfer && (xfer_sel == 4'd0) && (xfer_data != '0);
            if (xfer && (xfer_sel != 4'd0)) begin
                rf_wrt_sel  <= xfer_sel;
                rf_wrt_data <= xfer_data;
            end
        end
    end

    always_comb begin
        set_vec   = '0;
        clr_vec   = '0;
        iss_err_d = 1'b0;
        if (iss_en && (iss_sel != 4'd0))
            set_vec = NUM_REGS'(1) << iss_sel;
        if (rf_wrt_en)
            clr_vec = NUM_REGS'(1) << rf_wrt_sel;
        // A register retiring this very cycle is free to be issued again.
        iss_err_d = iss_en && (iss_sel != 4'd0) && pending[iss_sel] &&
                    !(rf_wrt_en && (rf_wrt_sel == iss_sel));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            iss_err <= 1'b0;
        end else begin
            pending <= ((pending & ~clr_vec) | set_vec) & ~NUM_REGS'(1);
            iss_err <= iss_err_d;
        end
    end

    // The register being written this cycle is bypassed by the register file.
    always_comb begin
        hazard = ((chk_sel1 != 4'd0) && pending[chk_sel1] &&
                  !(rf_wrt_en && (rf_wrt_sel == chk_sel1))) ||
                 ((chk_sel2 != 4'd0) && pending[chk_sel2] &&
                  !(rf_wrt_en && (rf_wrt_sel == chk_sel2)));
    end
endmodule

// File: tb/tb_cpu_rf_wb_arb.sv
// Directed bench for cpu_rf_wb_arb: arbitration, R0 drop, scoreboard and reset.
module tb_cpu_rf_wb_arb;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       req_valid;
    logic [2:0][3:0]  req_sel;
    logic [2:0][31:0] req_data;
    logic [2:0]       req_ready;
    logic             rf_wrt_en;
    logic [3:0]       rf_wrt_sel;
    logic [31:0]      rf_wrt_data;
    logic             iss_en;
    logic [3:0]       iss_sel;
    logic [3:0]       chk_sel1;
    logic [3:0]       chk_sel2;
    logic             hazard;
    logic [15:0]      pending;
    logic             r0_err;
    logic             iss_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_rf_wb_arb #(.NREQ(3), .DW(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_sel     (req_sel),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rf_wrt_en   (rf_wrt_en),
        .rf_wrt_sel  (rf_wrt_sel),
        .rf_wrt_data (rf_wrt_data),
        .iss_en      (iss_en),
        .iss_sel     (iss_sel),
        .chk_sel1    (chk_sel1),
        .chk_sel2    (chk_sel2),
        .hazard      (hazard),
        .pending     (pending),
        .r0_err      (r0_err),
        .iss_err     (iss_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] rot_ready [4];
    logic [3:0] rot_sel   [4];

    initial begin
        rot_ready[0] = 3'b010; rot_sel[0] = 4'd2;
        rot_ready[1] = 3'b100; rot_sel[1] = 4'd5;
        rot_ready[2] = 3'b001; rot_sel[2] = 4'd1;
        rot_ready[3] = 3'b010; rot_sel[3] = 4'd2;

        rst_n = 1'b0; req_valid = '0; req_sel = '0; req_data = '0;
        iss_en = 1'b0; iss_sel = '0; chk_sel1 = '0; chk_sel2 = '0;
        #12;
        chk("rst_wrt_en", 64'(rf_wrt_en), 64'd0);
        chk("rst_wrt_sel", 64'(rf_wrt_sel), 64'd0);
        chk("rst_wrt_data", 64'(rf_wrt_data), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_r0_err", 64'(r0_err), 64'd0);
        chk("rst_iss_err", 64'(iss_err), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single ALU write to R3.
        req_valid = 3'b001; req_sel[0] = 4'd3; req_data[0] = 32'hDEADBEEF;
        #1;
        chk("first_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = '0;
        chk("first_en", 64'(rf_wrt_en), 64'd1);
        chk("first_sel", 64'(rf_wrt_sel), 64'd3);
        chk("first_data", 64'(rf_wrt_data), 64'hDEADBEEF);
        #1;
        chk("idle_ready", 64'(req_ready), 64'd0);
        tick();
        chk("idle_en", 64'(rf_wrt_en), 64'd0);
        chk("idle_sel_hold", 64'(rf_wrt_sel), 64'd3);

        // All three valid: pointer is at 0, so rotation starts at requester 1.
        req_valid = 3'b111;
        req_sel[0] = 4'd1; req_data[0] = 32'hA;
        req_sel[1] = 4'd2; req_data[1] = 32'hB;
        req_sel[2] = 4'd5; req_data[2] = 32'hC;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rot_ready_%0d", i), 64'(req_ready), 64'(rot_ready[i]));
            tick();
            chk($sformatf("rot_en_%0d", i), 64'(rf_wrt_en), 64'd1);
            chk($sformatf("rot_sel_%0d", i), 64'(rf_wrt_sel), 64'(rot_sel[i]));
        end
        chk("rot_data_last", 64'(rf_wrt_data), 64'hB);
        req_valid = '0;

        // R0 with non-zero data, then with zero data.
        req_valid = 3'b100; req_sel[2] = 4'd0; req_data[2] = 32'd5;
        #1;
        chk("r0_ready", 64'(req_ready), 64'b100);
        tick();
        req_valid = '0;
        chk("r0_en", 64'(rf_wrt_en), 64'd0);
        chk("r0_err_pulse", 64'(r0_err), 64'd1);
        tick();
        chk("r0_err_drop", 64'(r0_err), 64'd0);
        req_valid = 3'b100; req_data[2] = 32'd0;
        tick();
        req_valid = '0;
        chk("r0z_en", 64'(rf_wrt_en), 64'd0);
        chk("r0z_err", 64'(r0_err), 64'd0);

        // Issue R7, observe the hazard through the write-back.
        iss_en = 1'b1; iss_sel = 4'd7;
        tick();
        iss_en = 1'b0; chk_sel1 = 4'd7;
        chk("iss7_pending", 64'(pending), 64'h0080);
        #1;
        chk("haz7_a", 64'(hazard), 64'd1);
        tick();
        chk("haz7_b", 64'(hazard), 64'd1);
        chk_sel1 = 4'd0; chk_sel2 = 4'd7;
        #1;
        chk("haz7_sel2", 64'(hazard), 64'd1);
        chk_sel1 = 4'd7; chk_sel2 = 4'd0;
        req_valid = 3'b001; req_sel[0] = 4'd7; req_data[0] = 32'h77;
        #1;
        chk("haz7_req_ready", 64'(req_ready), 64'b001);
        chk("haz7_before_wb", 64'(hazard), 64'd1);
        tick();
        req_valid = '0;
        chk("wb7_en", 64'(rf_wrt_en), 64'd1);
        chk("wb7_bypass", 64'(hazard), 64'd0);
        chk("wb7_pending_still", 64'(pending), 64'h0080);
        tick();
        chk("wb7_cleared", 64'(pending), 64'h0000);
        chk("wb7_haz_after", 64'(hazard), 64'd0);
        chk_sel1 = 4'd0;

        // Build pending=0x00F0, then set/clear collision on R4.
        for (int r = 4; r < 8; r++) begin
            iss_en = 1'b1; iss_sel = 4'(r);
            tick();
        end
        iss_en = 1'b0;
        chk("pend_f0", 64'(pending), 64'h00F0);
        req_valid = 3'b010; req_sel[1] = 4'd4; req_data[1] = 32'h44;
        #1;
        chk("r4_ready", 64'(req_ready), 64'b010);
        tick();
        req_valid = '0;
        chk("r4_en", 64'(rf_wrt_en), 64'd1);
        chk("r4_sel", 64'(rf_wrt_sel), 64'd4);
        iss_en = 1'b1; iss_sel = 4'd4;
        tick();
        chk("r4_set_wins", 64'(pending), 64'h00F0);
        tick();
        iss_en = 1'b0;
        chk("r4_iss_err", 64'(iss_err), 64'd1);
        chk("r4_still_pend", 64'(pending), 64'h00F0);
        tick();
        chk("r4_iss_err_drop", 64'(iss_err), 64'd0);

        // Reset while a write is on the port with pending=0x00F0.
        req_valid = 3'b001; req_sel[0] = 4'd1; req_data[0] = 32'h11;
        #1;
        chk("pre_rst_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = '0;
        chk("pre_rst_en", 64'(rf_wrt_en), 64'd1);
        chk("pre_rst_pend", 64'(pending), 64'h00F0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_en", 64'(rf_wrt_en), 64'd0);
        chk("async_rst_sel", 64'(rf_wrt_sel), 64'd0);
        chk("async_rst_data", 64'(rf_wrt_data), 64'd0);
        chk("async_rst_pend", 64'(pending), 64'd0);
        #3;
        rst_n = 1'b1;
        req_valid = 3'b111;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = '0;
        chk("post_rst_sel", 64'(rf_wrt_sel), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
